regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning write-data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register-address width.
REQ-003 The block SHALL have port clk, input, 1, system clock.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port hold, input, 1, meaning the block grants no requester while high.
REQ-006 The block SHALL have ports req0_valid input 1, req0_addr input ADDR_W and req0_data input DATA_W, the pipeline writeback requester.
REQ-007 The block SHALL have port req0_ready, output, 1, the requester-0 grant, combinational.
REQ-008 The block SHALL have ports req1_valid input 1, req1_addr input ADDR_W and req1_data input DATA_W, the multicycle/load writeback requester.
REQ-009 The block SHALL have port req1_ready, output, 1, the requester-1 grant, combinational.
REQ-010 The block SHALL have ports rf_we output 1, rf_waddr output ADDR_W and rf_wdata output DATA_W, all registered, driving the register-file write port.
REQ-011 The block SHALL have port collide_cnt, output, 8, a saturating count of same-address collisions.

Function
REQ-012 A request SHALL transfer in a cycle where reqN_valid and reqN_ready are both high; at most one ready SHALL be high per cycle.
REQ-013 With hold high, both readys SHALL be 0; rf_we SHALL be 0 on the next edge.
REQ-014 When only one valid is high, that requester SHALL be granted in the same cycle.
REQ-015 When both valids are high with different addresses, the grant SHALL go to the requester other than the one in the last-grant pointer.
REQ-016 When both valids are high with equal addresses, req1 SHALL be granted first so that req0's value is the final one written; collide_cnt SHALL increment and saturate at 255.
REQ-017 The last-grant pointer SHALL update to the granted index on every transfer; it SHALL hold when there is no transfer.
REQ-018 A transfer SHALL register rf_we=1, rf_waddr and rf_wdata one edge later, giving 1-cycle latency.
REQ-019 A transfer to address 0 SHALL be accepted, with ready high, and SHALL register rf_we=0.
REQ-020 A cycle with no transfer SHALL register rf_we=0; rf_waddr and rf_wdata SHALL hold their values.
REQ-021 Requester inputs SHALL be sampled only in the cycle they transfer; a requester SHALL hold valid, addr and data stable until ready.

Reset
REQ-022 Reset SHALL asynchronously force rf_we=0, rf_waddr=0, rf_wdata=0, collide_cnt=0 and pointer=1, so req0 wins the first different-address tie.
REQ-023 While reset is low, both readys SHALL be 0; a request in flight SHALL be dropped, not written.
REQ-024 The first transfer SHALL be possible in the first clk edge after reset deasserts.

Structure
REQ-025 ADDR_W/DATA_W defaults, the REG_ZERO constant and the requester-index enum (REQ_PIPE=0, REQ_LONG=1) SHALL reside in shared package cpu_wb_pkg.
REQ-026 Grant selection (valids, address-equal flag, pointer -> grant vector) SHALL be the sub-module wb_rr_pick; regfile_wb_arbiter SHALL hold the pointer, output register and counter.

Verification
REQ-027 Scenario: req0 valid alone, addr 3, data 0x11 -> req0_ready=1 same cycle; next cycle rf_we=1, waddr=3, wdata=0x11.
REQ-028 Scenario: both valid from reset, addr 4/5, data 0xA/0xB held -> cycle 1 req0 granted, cycle 2 req1 granted; rf writes 4:0xA then 5:0xB.
REQ-029 Scenario: both valid, addr 7, data 0x1 (req0)/0x2 (req1) -> req1 first, then req0; final reg7 value 0x1; collide_cnt=1.
REQ-030 Scenario: req1 valid, addr 0 -> req1_ready=1; rf_we stays 0.
REQ-031 Scenario: hold=1 for 3 cycles with both valid -> no ready, rf_we=0; hold=0 -> grants resume per pointer.
REQ-032 Scenario: reset asserted mid-stream with both valid -> outputs 0 immediately, readys 0; after release req0 wins the first tie.

Source files
------------

// File: rtl/cpu_wb_pkg.sv
// cpu_wb_pkg: shared writeback widths, zero-register constant and requester index
package cpu_wb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;
    typedef enum logic {REQ_PIPE = 1'b0, REQ_LONG = 1'b1} req_idx_e;
endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: two-way writeback grant selection
//   valid   - gated requester valids (bit N = requester N)
//   addr_eq - both requesters target the same register
//   last    - requester granted most recently
//   grant   - one-hot (or zero) grant vector
module wb_rr_pick
    import cpu_wb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       addr_eq,
    input  req_idx_e   last,
    output logic [1:0] grant
);
    // Same-address ties always go to the long requester first so the
    // pipeline value, being younger, lands last in the register file.
    always_comb grant = &valid ? ((addr_eq || last == REQ_PIPE) ? 2'b10 : 2'b01) : valid;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates two writeback requesters onto one register-file write port
//   clk, reset (async, active-low), hold (suppress all grants)
//   req0_* - pipeline writeback requester, req1_* - multicycle/load requester
//   rf_we/rf_waddr/rf_wdata - registered register-file write port
//   collide_cnt - saturating count of same-address collisions
module regfile_wb_arbiter
    import cpu_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [7:0]        collide_cnt
);
    logic [1:0]        valid;
    logic [1:0]        grant;
    logic              addr_eq;
    logic              xfer;
    logic              wr;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    req_idx_e          last;
    req_idx_e          gidx;

    // Grants are blocked outright during reset so an in-flight request is dropped.
    assign valid   = {req1_valid, req0_valid} & {2{reset & ~hold}};
    assign addr_eq = req0_addr == req1_addr;

    wb_rr_pick u_pick (
        .valid   (valid),
        .addr_eq (addr_eq),
        .last    (last),
        .grant   (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign xfer       = |grant;
    assign gidx       = grant[1] ? REQ_LONG : REQ_PIPE;
    assign waddr      = grant[1] ? req1_addr : req0_addr;
    assign wdata      = grant[1] ? req1_data : req0_data;
    // Register zero is hardwired, so its writes are accepted but discarded.
    assign wr         = xfer && waddr != ADDR_W'(REG_ZERO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            collide_cnt <= '0;
            last        <= REQ_LONG;
        end else begin
            rf_we <= wr;
            if (wr) begin
                rf_waddr <= waddr;
                rf_wdata <= wdata;
            end
            if (xfer) last <= gidx;
            if (&valid && addr_eq && collide_cnt != 8'hFF) collide_cnt <= collide_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hold = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [4:0]  req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [7:0]  collide_cnt;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;
    wr_t q[$];
    int  total = 0, bad = 0, cyc = 0;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .collide_cnt (collide_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        w.c = cyc + 1;
        q.push_back(w);
    endtask

    // Drive one cycle at the falling edge and check the combinational grants.
    task automatic step(input string nm, input logic r, input logic h,
                        input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic e0, input logic e1);
        @(negedge clk);
        reset = r; hold = h;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        chk({nm, ".r0"}, 32'(req0_ready), 32'(e0));
        chk({nm, ".r1"}, 32'(req1_ready), 32'(e1));
        if (e0 && a0 != 5'd0) push(a0, d0);
        if (e1 && a1 != 5'd0) push(a1, d1);
    endtask

    task automatic idle(input string nm);
        step(nm, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rf_we === 1'b1) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write got=%h:%h exp=none", rf_waddr, rf_wdata);
                end else begin
                    e = q.pop_front();
                    chk("wr_addr", 32'(rf_waddr), 32'(e.a));
                    chk("wr_data", rf_wdata, e.d);
                    chk("wr_cycle", cyc, e.c);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with both valid: no grants, outputs cleared.
        step("rst", 1'b0, 1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0, 1'b0);
        chk("rst.we", 32'(rf_we), 0);
        chk("rst.waddr", 32'(rf_waddr), 0);
        chk("rst.wdata", rf_wdata, 0);
        chk("rst.cnt", 32'(collide_cnt), 0);
        // First tie after reset goes to req0, then pointer alternates.
        step("tie1", 1'b1, 1'b0, 1'b1, 5'd4, 32'hA, 1'b1, 5'd5, 32'hB, 1'b1, 1'b0);
        step("tie2", 1'b1, 1'b0, 1'b1, 5'd6, 32'hC, 1'b1, 5'd5, 32'hB, 1'b0, 1'b1);
        step("tie3", 1'b1, 1'b0, 1'b1, 5'd6, 32'hC, 1'b1, 5'd8, 32'hD, 1'b1, 1'b0);
        step("solo1", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'hD, 1'b0, 1'b1);
        step("solo0", 1'b1, 1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        // Same-address collision: req1 first, req0 last.
        step("col1", 1'b1, 1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b0, 1'b1);
        step("col0", 1'b1, 1'b0, 1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        chk("col.cnt", 32'(collide_cnt), 1);
        idle("idle");
        @(posedge clk); #1;
        chk("idle.we", 32'(rf_we), 0);
        chk("idle.waddr", 32'(rf_waddr), 7);
        chk("idle.wdata", rf_wdata, 32'h1);
        // Register zero: accepted, never written.
        step("zero", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, 1'b0, 1'b1);
        idle("zero_idle");
        // Hold blocks everything; pointer (last=req1) resumes with req0.
        for (int i = 0; i < 3; i++)
            step("hold", 1'b1, 1'b1, 1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b0);
        step("unhold0", 1'b1, 1'b0, 1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0, 1'b1, 1'b0);
        step("unhold1", 1'b1, 1'b0, 1'b1, 5'd11, 32'hB0, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b1);
        step("unhold2", 1'b1, 1'b0, 1'b1, 5'd11, 32'hB0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        // Saturation: 256 more collisions on top of the one already counted.
        for (int i = 0; i < 256; i++)
            step("sat", 1'b1, 1'b0, 1'b1, 5'd2, 32'h7, 1'b1, 5'd2, 32'(i), 1'b0, 1'b1);
        idle("sat_idle");
        chk("sat.cnt", 32'(collide_cnt), 255);
        // Mid-stream reset: pointer is req1, so req0 takes this tie.
        step("pre_rst", 1'b1, 1'b0, 1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0, 1'b1, 1'b0);
        step("mid_rst", 1'b0, 1'b0, 1'b1, 5'd14, 32'hE0, 1'b1, 5'd13, 32'hD0, 1'b0, 1'b0);
        chk("mid_rst.we", 32'(rf_we), 0);
        chk("mid_rst.waddr", 32'(rf_waddr), 0);
        chk("mid_rst.wdata", rf_wdata, 0);
        chk("mid_rst.cnt", 32'(collide_cnt), 0);
        step("post_rst0", 1'b1, 1'b0, 1'b1, 5'd14, 32'hE0, 1'b1, 5'd13, 32'hD0, 1'b1, 1'b0);
        step("post_rst1", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hD0, 1'b0, 1'b1);
        idle("end0");
        idle("end1");
        @(posedge clk); #2;
        chk("sb_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
